seq_arith_unit: RTL

- Parametrised, multi-cycle successor to the combinational SAYEH ALU.
- Single-cycle logic, shift, add, sub and compare ops, plus an iterative full-width multiply (2*WIDTH product) and unsigned divide (quotient and remainder).
- Uses a start/busy/done handshake and registered flags.
- Sits between the register file and the datapath; the controller stalls on busy.

---
 rtl/seq_arith_pkg.sv | 84 ++++++++
 rtl/seq_arith_iter.sv | 70 +++++++
 rtl/seq_arith_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/seq_arith_pkg.sv
// seq_arith_pkg: shared definitions for the sequential arithmetic unit.
//   - op code values sampled on seq_arith_unit.op
//   - controller state type
//   - exec_single(): result of every single-cycle op, evaluated at up to
//     MAX_W bits and masked to the active width w
package seq_arith_pkg;

  localparam int unsigned MAX_W = 64;

  localparam logic [3:0] PASSB = 4'd0;
  localparam logic [3:0] AND   = 4'd1;
  localparam logic [3:0] OR    = 4'd2;
  localparam logic [3:0] NOTB  = 4'd3;
  localparam logic [3:0] SHL   = 4'd4;
  localparam logic [3:0] SHR   = 4'd5;
  localparam logic [3:0] ADD   = 4'd6;
  localparam logic [3:0] SUB   = 4'd7;
  localparam logic [3:0] MUL   = 4'd8;
  localparam logic [3:0] CMP   = 4'd9;
  localparam logic [3:0] DIV   = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_ITER,
    S_FIN
  } state_t;

  typedef struct packed {
    logic [MAX_W-1:0] res;
    logic             cout;
  } exec_t;

  // Operands arrive zero-extended to MAX_W; bit w of the MAX_W+1 bit
  // add/sub result is therefore the carry/borrow out of a w-bit operation.
  function automatic exec_t exec_single(
    input logic [3:0]       op,
    input logic [MAX_W-1:0] a,
    input logic [MAX_W-1:0] b,
    input logic             cin,
    input logic [6:0]       w
  );
    exec_t            r;
    logic [MAX_W-1:0] mask;
    logic [MAX_W:0]   wide;
    logic             msb;
    // 1<<64 wraps to 0 in MAX_W bits, so w=64 yields an all-ones mask.
    mask = (MAX_W'(1) << w) - MAX_W'(1);
    wide = '0;
    msb  = b[6'(w - 7'd1)];
    r    = '0;
    case (op)
      PASSB: r.res = b;
      AND:   r.res = a & b;
      OR:    r.res = a | b;
      NOTB:  r.res = ~b & mask;
      SHL: begin
        r.res  = (b << 1) & mask;
        r.cout = msb;
      end
      SHR: begin
        r.res  = (b >> 1) | (MAX_W'(msb) << (w - 7'd1));
        r.cout = b[0];
      end
      ADD: begin
        wide   = {1'b0, a} + {1'b0, b} + {{MAX_W{1'b0}}, cin};
        r.res  = wide[MAX_W-1:0] & mask;
        r.cout = wide[w];
      end
      SUB: begin
        wide   = {1'b0, a} - {1'b0, b} - {{MAX_W{1'b0}}, cin};
        r.res  = wide[MAX_W-1:0] & mask;
        r.cout = wide[w];
      end
      CMP: begin
        r.res  = a;
        r.cout = (a > b);
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seq_arith_iter.sv
// seq_arith_iter: shared shift datapath for MUL and DIV.
//   clk, rst_n   clock, async active-low reset
//   load_i       load acc={0,A}, operand=B, latch mode
//   step_i       perform one iteration
//   div_mode_i   0: shift-add multiply, 1: restoring divide
//   a_i, b_i     operands (sampled on load_i)
//   acc_o        2W accumulator: MUL {hi,lo}; DIV {remainder,quotient}
module seq_arith_iter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               div_mode_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               div_q, div_d;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     part;

  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    div_d  = div_q;
    sum    = '0;
    part   = '0;
    if (load_i) begin
      acc_d  = {{WIDTH{1'b0}}, a_i};
      opnd_d = b_i;
      div_d  = div_mode_i;
    end else if (step_i) begin
      if (!div_q) begin
        // Add multiplicand into the high half when the current multiplier
        // bit is set, then shift the whole accumulator right.
        sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        acc_d = {sum, acc_q[WIDTH-1:1]};
      end else begin
        // Shifted partial remainder needs W+1 bits; sum[WIDTH] is the borrow.
        part = acc_q[2*WIDTH-1:WIDTH-1];
        sum  = part - {1'b0, opnd_q};
        if (!sum[WIDTH]) begin
          acc_d = {sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {part[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      div_q  <= div_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/seq_arith_unit.sv
// seq_arith_unit: multi-cycle ALU with start/busy/done handshake.
//   clk, rst_n     clock, async active-low reset
//   start          launch request, accepted only in IDLE
//   op, A, B, cin  operation and operands, sampled with start
//   aluout         result / low product word / quotient
//   aux_out        high product word / remainder / A on divide-by-zero
//   zout, cout     zero and carry/borrow/compare/overflow flags
//   dz_err         divide-by-zero flag
//   busy           operation in progress (EXEC/ITER)
//   done           one-cycle pulse in FIN; outputs valid from this cycle
module seq_arith_unit
  import seq_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] aluout,
  output logic [WIDTH-1:0] aux_out,
  output logic             zout,
  output logic             cout,
  output logic             dz_err,
  output logic             busy,
  output logic             done
);

  state_t             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               cin_q, cin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   aluout_q, aluout_d;
  logic [WIDTH-1:0]   aux_q, aux_d;
  logic               zout_q, zout_d;
  logic               cout_q, cout_d;
  logic               dz_q, dz_d;
  logic               iter_load, iter_step;
  logic [2*WIDTH-1:0] acc;
  exec_t              ex;

  seq_arith_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (iter_load),
    .step_i    (iter_step),
    .div_mode_i(op == DIV),
    .a_i       (A),
    .b_i       (B),
    .acc_o     (acc)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    cin_d     = cin_q;
    cnt_d     = cnt_q;
    aluout_d  = aluout_q;
    aux_d     = aux_q;
    zout_d    = zout_q;
    cout_d    = cout_q;
    dz_d      = dz_q;
    iter_load = 1'b0;
    iter_step = 1'b0;
    ex        = exec_single(op_q, MAX_W'(a_q), MAX_W'(b_q), cin_q, 7'(WIDTH));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = op;
          a_d   = A;
          b_d   = B;
          cin_d = cin;
          if (op == MUL || (op == DIV && B != '0)) begin
            state_d   = S_ITER;
            cnt_d     = CNT_W'(WIDTH);
            iter_load = 1'b1;
          end else begin
            // Divide-by-zero takes the EXEC slot so its latency matches
            // the single-cycle ops.
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        if (op_q == DIV) begin
          aluout_d = '1;
          aux_d    = a_q;
          cout_d   = 1'b0;
          zout_d   = 1'b0;
          dz_d     = 1'b1;
        end else begin
          aluout_d = ex.res[WIDTH-1:0];
          aux_d    = '0;
          cout_d   = ex.cout;
          zout_d   = (op_q == CMP) ? (a_q == b_q) : (ex.res == '0);
          dz_d     = 1'b0;
        end
        state_d = S_FIN;
      end
      S_ITER: begin
        if (cnt_q != '0) begin
          iter_step = 1'b1;
          cnt_d     = cnt_q - CNT_W'(1);
        end else begin
          aluout_d = acc[WIDTH-1:0];
          aux_d    = acc[2*WIDTH-1:WIDTH];
          cout_d   = (op_q == MUL) ? (acc[2*WIDTH-1:WIDTH] != '0) : 1'b0;
          zout_d   = (acc == '0);
          dz_d     = 1'b0;
          state_d  = S_FIN;
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      cnt_q    <= '0;
      aluout_q <= '0;
      aux_q    <= '0;
      zout_q   <= 1'b0;
      cout_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      cnt_q    <= cnt_d;
      aluout_q <= aluout_d;
      aux_q    <= aux_d;
      zout_q   <= zout_d;
      cout_q   <= cout_d;
      dz_q     <= dz_d;
    end
  end

  assign aluout  = aluout_q;
  assign aux_out = aux_q;
  assign zout    = zout_q;
  assign cout    = cout_q;
  assign dz_err  = dz_q;
  assign busy    = (state_q == S_EXEC) || (state_q == S_ITER);
  assign done    = (state_q == S_FIN);

endmodule
